// File: rtl/load_store_unit.sv
// RV32I load/store unit: one access at a time over a req/gnt/rvalid memory port, with timeout abort.
// Optional build macro LSU_MISALIGN_TRAP_EN: trap misaligned halfword/word accesses instead of force-aligning them.
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        misaligned,
  output logic        bus_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 32'd1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(32'd1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  function automatic logic illegal_f(input logic st, input logic [2:0] f3);
    logic bad;
    case (f3)
      3'b011, 3'b110, 3'b111: bad = 1'b1;
      3'b100, 3'b101:         bad = st;
      default:                bad = 1'b0;
    endcase
    return bad;
  endfunction

  function automatic logic [31:0] align_f(input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] r;
    case (f3[1:0])
      2'b01:   r = {a[31:1], 1'b0};
      2'b10:   r = {a[31:2], 2'b00};
      default: r = a;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] wstrb_f(input logic st, input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] s;
    if (!st) begin
      s = 4'b0000;
    end else begin
      case (f3[1:0])
        2'b00:   s = 4'b0001 << off;
        2'b01:   s = 4'b0011 << off;
        2'b10:   s = 4'b1111;
        default: s = 4'b0000;
      endcase
    end
    return s;
  endfunction

  function automatic logic [31:0] wdata_f(input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] r;
    case (f3[1:0])
      2'b00:   r = {4{wd[7:0]}};
      2'b01:   r = {2{wd[15:0]}};
      default: r = wd;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] extract_f(input logic [2:0] f3, input logic [1:0] off,
                                            input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'b00:   b = rd[7:0];
      2'b01:   b = rd[15:8];
      2'b10:   b = rd[23:16];
      default: b = rd[31:24];
    endcase
    h = off[1] ? rd[31:16] : rd[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b100:  r = {24'd0, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b101:  r = {16'd0, h};
      3'b010:  r = rd;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  logic [1:0]    state_r;
  logic [1:0]    state_next_s;
  logic [CW-1:0] cnt_r;
  logic          is_store_r;
  logic [2:0]    funct3_r;
  logic [1:0]    off_r;
  logic          busy_r, done_r, mem_req_r, mem_we_r, mis_r, berr_r;
  logic [31:0]   rdata_r, mem_addr_r, mem_wdata_r;
  logic [3:0]    mem_wstrb_r;

  logic          trap_s, reject_s, timeout_s, finish_s;
  logic [31:0]   addr_align_s;
  logic [31:0]   res_rdata_s;
  logic          res_mis_s, res_berr_s;

  // Misalignment trap vs. forced natural alignment, selected at build time.
  always_comb begin
`ifdef LSU_MISALIGN_TRAP_EN
    case (funct3[1:0])
      2'b01:   trap_s = addr[0];
      2'b10:   trap_s = (addr[1:0] != 2'b00);
      default: trap_s = 1'b0;
    endcase
    addr_align_s = addr;
`else
    trap_s       = 1'b0;
    addr_align_s = align_f(funct3, addr);
`endif
  end

  assign reject_s  = illegal_f(is_store, funct3) | trap_s;
  assign timeout_s = (cnt_r == CNT_LAST);

  // Next state and the result captured on entry to DONE; a response beats a same-cycle timeout.
  always_comb begin
    state_next_s = state_r;
    finish_s     = 1'b0;
    res_rdata_s  = 32'd0;
    res_mis_s    = 1'b0;
    res_berr_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start && reject_s) begin
          state_next_s = ST_DONE;
          finish_s     = 1'b1;
          res_mis_s    = 1'b1;
        end else if (start) begin
          state_next_s = ST_REQ;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (mem_gnt && is_store_r) begin
          state_next_s = ST_DONE;
          finish_s     = 1'b1;
        end else if (mem_gnt) begin
          state_next_s = ST_WAIT;
        end else if (timeout_s) begin
          state_next_s = ST_DONE;
          finish_s     = 1'b1;
          res_berr_s   = 1'b1;
        end else begin
          state_next_s = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (mem_rvalid) begin
          state_next_s = ST_DONE;
          finish_s     = 1'b1;
          res_rdata_s  = extract_f(funct3_r, off_r, mem_rdata);
        end else if (timeout_s) begin
          state_next_s = ST_DONE;
          finish_s     = 1'b1;
          res_berr_s   = 1'b1;
        end else begin
          state_next_s = ST_WAIT;
        end
      end
      ST_DONE: state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // State, timeout counter, memory-port and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      cnt_r       <= '0;
      is_store_r  <= 1'b0;
      funct3_r    <= 3'd0;
      off_r       <= 2'd0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= 32'd0;
      mem_wdata_r <= 32'd0;
      mem_wstrb_r <= 4'd0;
      rdata_r     <= 32'd0;
      mis_r       <= 1'b0;
      berr_r      <= 1'b0;
    end else begin
      state_r   <= state_next_s;
      busy_r    <= (state_next_s != ST_IDLE);
      done_r    <= (state_next_s == ST_DONE);
      mem_req_r <= (state_next_s == ST_REQ);

      if (state_r == ST_IDLE) begin
        cnt_r <= '0;
      end else if ((state_r == ST_REQ) || (state_r == ST_WAIT)) begin
        cnt_r <= cnt_r + CNT_ONE;
      end else begin
        cnt_r <= cnt_r;
      end

      if ((state_r == ST_IDLE) && start) begin
        is_store_r <= is_store;
        funct3_r   <= funct3;
        off_r      <= addr_align_s[1:0];
      end
      // Memory-port fields only change when a request is actually issued.
      if ((state_r == ST_IDLE) && start && !reject_s) begin
        mem_we_r    <= is_store;
        mem_addr_r  <= {addr_align_s[31:2], 2'b00};
        mem_wdata_r <= wdata_f(funct3, wdata);
        mem_wstrb_r <= wstrb_f(is_store, funct3, addr_align_s[1:0]);
      end

      if (finish_s) begin
        rdata_r <= res_rdata_s;
        mis_r   <= res_mis_s;
        berr_r  <= res_berr_s;
      end
    end
  end

  assign busy       = busy_r;
  assign done       = done_r;
  assign rdata      = rdata_r;
  assign misaligned = mis_r;
  assign bus_err    = berr_r;
  assign mem_req    = mem_req_r;
  assign mem_we     = mem_we_r;
  assign mem_addr   = mem_addr_r;
  assign mem_wdata  = mem_wdata_r;
  assign mem_wstrb  = mem_wstrb_r;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed, table-driven bench for load_store_unit (TIMEOUT_CYCLES=4) plus hand-written reset/busy sequences.
module tb_load_store_unit;

  localparam int unsigned TO = 4;

  logic        clk;
  logic        rst;
  logic        start;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] rdata;
  logic        misaligned;
  logic        bus_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  int n_checks = 0;
  int n_errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .is_store(is_store), .funct3(funct3),
    .addr(addr), .wdata(wdata), .busy(busy), .done(done), .rdata(rdata),
    .misaligned(misaligned), .bus_err(bus_err), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  typedef struct {
    string       name;
    logic        st;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] wd;
    int          gnt_dly;
    int          rv_dly;
    logic [31:0] rd;
    logic        exp_req;
    logic [31:0] exp_maddr;
    logic [3:0]  exp_strb;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
    logic        exp_mis;
    logic        exp_berr;
    int          exp_lat;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_b(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_i(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string name, input logic st, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] wd, input int g, input int r,
                              input logic [31:0] rd, input logic req, input logic [31:0] maddr,
                              input logic [3:0] strb, input logic [31:0] ewd, input logic [31:0] erd,
                              input logic mis, input logic berr, input int lat);
    vec_t v;
    v.name = name; v.st = st; v.f3 = f3; v.a = a; v.wd = wd; v.gnt_dly = g; v.rv_dly = r;
    v.rd = rd; v.exp_req = req; v.exp_maddr = maddr; v.exp_strb = strb; v.exp_wdata = ewd;
    v.exp_rdata = erd; v.exp_mis = mis; v.exp_berr = berr; v.exp_lat = lat;
    return v;
  endfunction

  // One access: drive start, play memory responder per vector delays, check port fields and result.
  task automatic run_vec(input vec_t v);
    int lat;
    int req_cyc;
    int wait_cyc;
    bit seen_req;
    bit gnt_given;
    lat = 0; req_cyc = 0; wait_cyc = 0; seen_req = 1'b0; gnt_given = 1'b0;
    @(negedge clk);
    start = 1'b1; is_store = v.st; funct3 = v.f3; addr = v.a; wdata = v.wd;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      start = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
      if (done) begin
        lat = c;
        break;
      end
      if (mem_req) begin
        if (!seen_req) begin
          check({v.name, " mem_addr"}, mem_addr, v.exp_maddr);
          check_b({v.name, " mem_we"}, mem_we, v.st);
          check({v.name, " mem_wstrb"}, {28'd0, mem_wstrb}, {28'd0, v.exp_strb});
          if (v.st) check({v.name, " mem_wdata"}, mem_wdata, v.exp_wdata);
        end
        seen_req = 1'b1;
        if (req_cyc == v.gnt_dly) begin
          mem_gnt = 1'b1;
          gnt_given = 1'b1;
        end
        req_cyc++;
      end else if (gnt_given && busy) begin
        if (wait_cyc == v.rv_dly) begin
          mem_rvalid = 1'b1;
          mem_rdata = v.rd;
        end
        wait_cyc++;
      end
    end
    check_i({v.name, " latency"}, lat, v.exp_lat);
    check_b({v.name, " req_seen"}, seen_req, v.exp_req);
    check_b({v.name, " mem_req@done"}, mem_req, 1'b0);
    check_b({v.name, " misaligned"}, misaligned, v.exp_mis);
    check_b({v.name, " bus_err"}, bus_err, v.exp_berr);
    if (!v.st && !v.exp_mis) check({v.name, " rdata"}, rdata, v.exp_rdata);
    @(negedge clk);
    check_b({v.name, " done 1-cycle"}, done, 1'b0);
    check_b({v.name, " idle"}, busy, 1'b0);
    repeat (2) @(negedge clk);
    if (!v.st && !v.exp_mis) check({v.name, " rdata hold"}, rdata, v.exp_rdata);
  endtask

  initial begin
    int          dones;
    logic [31:0] got;
    logic        got_mis;

    rst = 1'b1; start = 1'b0; is_store = 1'b0; funct3 = 3'd0; addr = 32'd0; wdata = 32'd0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;

    vecs.push_back(mk("SB 1003", 1'b1, 3'b000, 32'h1003, 32'h0000_00A5, 0, 0, 32'd0,
                      1'b1, 32'h1000, 4'b1000, 32'hA5A5_A5A5, 32'd0, 1'b0, 1'b0, 2));
    vecs.push_back(mk("SH 1002", 1'b1, 3'b001, 32'h1002, 32'h1234_BEEF, 0, 0, 32'd0,
                      1'b1, 32'h1000, 4'b1100, 32'hBEEF_BEEF, 32'd0, 1'b0, 1'b0, 2));
    vecs.push_back(mk("SW gnt+2", 1'b1, 3'b010, 32'h1004, 32'hDEAD_BEEF, 2, 0, 32'd0,
                      1'b1, 32'h1004, 4'b1111, 32'hDEAD_BEEF, 32'd0, 1'b0, 1'b0, 4));
    vecs.push_back(mk("SB 1000", 1'b1, 3'b000, 32'h1000, 32'h0000_003C, 0, 0, 32'd0,
                      1'b1, 32'h1000, 4'b0001, 32'h3C3C_3C3C, 32'd0, 1'b0, 1'b0, 2));
    vecs.push_back(mk("LB 2002", 1'b0, 3'b000, 32'h2002, 32'd0, 0, 0, 32'h12F4_5678,
                      1'b1, 32'h2000, 4'b0000, 32'd0, 32'hFFFF_FFF4, 1'b0, 1'b0, 3));
    vecs.push_back(mk("LBU 2002", 1'b0, 3'b100, 32'h2002, 32'd0, 0, 0, 32'h12F4_5678,
                      1'b1, 32'h2000, 4'b0000, 32'd0, 32'h0000_00F4, 1'b0, 1'b0, 3));
    vecs.push_back(mk("LB 2003", 1'b0, 3'b000, 32'h2003, 32'd0, 0, 0, 32'h7F00_0000,
                      1'b1, 32'h2000, 4'b0000, 32'd0, 32'h0000_007F, 1'b0, 1'b0, 3));
    vecs.push_back(mk("LH 2002 rv+1", 1'b0, 3'b001, 32'h2002, 32'd0, 0, 1, 32'h8001_7FFF,
                      1'b1, 32'h2000, 4'b0000, 32'd0, 32'hFFFF_8001, 1'b0, 1'b0, 4));
    vecs.push_back(mk("LHU 2000", 1'b0, 3'b101, 32'h2000, 32'd0, 0, 0, 32'h8001_7FFF,
                      1'b1, 32'h2000, 4'b0000, 32'd0, 32'h0000_7FFF, 1'b0, 1'b0, 3));
    vecs.push_back(mk("LW 2004", 1'b0, 3'b010, 32'h2004, 32'd0, 0, 0, 32'hCAFE_F00D,
                      1'b1, 32'h2004, 4'b0000, 32'd0, 32'hCAFE_F00D, 1'b0, 1'b0, 3));
`ifdef LSU_MISALIGN_TRAP_EN
    vecs.push_back(mk("LH 3001", 1'b0, 3'b001, 32'h3001, 32'd0, 0, 0, 32'h1234_89AB,
                      1'b0, 32'd0, 4'b0000, 32'd0, 32'd0, 1'b1, 1'b0, 1));
    vecs.push_back(mk("LW 2007", 1'b0, 3'b010, 32'h2007, 32'd0, 0, 0, 32'h0BAD_CAFE,
                      1'b0, 32'd0, 4'b0000, 32'd0, 32'd0, 1'b1, 1'b0, 1));
    vecs.push_back(mk("SH 1001", 1'b1, 3'b001, 32'h1001, 32'h0000_C3D4, 0, 0, 32'd0,
                      1'b0, 32'd0, 4'b0000, 32'd0, 32'd0, 1'b1, 1'b0, 1));
`else
    vecs.push_back(mk("LH 3001", 1'b0, 3'b001, 32'h3001, 32'd0, 0, 0, 32'h1234_89AB,
                      1'b1, 32'h3000, 4'b0000, 32'd0, 32'hFFFF_89AB, 1'b0, 1'b0, 3));
    vecs.push_back(mk("LW 2007", 1'b0, 3'b010, 32'h2007, 32'd0, 0, 0, 32'h0BAD_CAFE,
                      1'b1, 32'h2004, 4'b0000, 32'd0, 32'h0BAD_CAFE, 1'b0, 1'b0, 3));
    vecs.push_back(mk("SH 1001", 1'b1, 3'b001, 32'h1001, 32'h0000_C3D4, 0, 0, 32'd0,
                      1'b1, 32'h1000, 4'b0011, 32'hC3D4_C3D4, 32'd0, 1'b0, 1'b0, 2));
`endif
    vecs.push_back(mk("ld f3=011", 1'b0, 3'b011, 32'h2000, 32'd0, 0, 0, 32'd0,
                      1'b0, 32'd0, 4'b0000, 32'd0, 32'd0, 1'b1, 1'b0, 1));
    vecs.push_back(mk("st f3=100", 1'b1, 3'b100, 32'h1000, 32'h55, 0, 0, 32'd0,
                      1'b0, 32'd0, 4'b0000, 32'd0, 32'd0, 1'b1, 1'b0, 1));
    vecs.push_back(mk("st f3=110", 1'b1, 3'b110, 32'h1000, 32'h55, 0, 0, 32'd0,
                      1'b0, 32'd0, 4'b0000, 32'd0, 32'd0, 1'b1, 1'b0, 1));
    vecs.push_back(mk("ld f3=111", 1'b0, 3'b111, 32'h2000, 32'd0, 0, 0, 32'd0,
                      1'b0, 32'd0, 4'b0000, 32'd0, 32'd0, 1'b1, 1'b0, 1));
    vecs.push_back(mk("LW gnt timeout", 1'b0, 3'b010, 32'h2008, 32'd0, 99, 0, 32'h1111_1111,
                      1'b1, 32'h2008, 4'b0000, 32'd0, 32'd0, 1'b0, 1'b1, 5));
    vecs.push_back(mk("LW after timeout", 1'b0, 3'b010, 32'h200C, 32'd0, 0, 0, 32'h0102_0304,
                      1'b1, 32'h200C, 4'b0000, 32'd0, 32'h0102_0304, 1'b0, 1'b0, 3));
    vecs.push_back(mk("LH rvalid timeout", 1'b0, 3'b001, 32'h2000, 32'd0, 0, 99, 32'h2222_2222,
                      1'b1, 32'h2000, 4'b0000, 32'd0, 32'd0, 1'b0, 1'b1, 5));
    vecs.push_back(mk("LW rvalid@timeout", 1'b0, 3'b010, 32'h2010, 32'd0, 1, 1, 32'h7654_3210,
                      1'b1, 32'h2010, 4'b0000, 32'd0, 32'h7654_3210, 1'b0, 1'b0, 5));
    vecs.push_back(mk("SW gnt@timeout", 1'b1, 3'b010, 32'h1008, 32'h0F0F_0F0F, 3, 0, 32'd0,
                      1'b1, 32'h1008, 4'b1111, 32'h0F0F_0F0F, 32'd0, 1'b0, 1'b0, 5));

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_b("rst busy", busy, 1'b0);
    check_b("rst done", done, 1'b0);
    check_b("rst mem_req", mem_req, 1'b0);
    check_b("rst mem_we", mem_we, 1'b0);
    check_b("rst misaligned", misaligned, 1'b0);
    check_b("rst bus_err", bus_err, 1'b0);
    check("rst rdata", rdata, 32'd0);
    check("rst mem_addr", mem_addr, 32'd0);
    check("rst mem_wdata", mem_wdata, 32'd0);
    check("rst mem_wstrb", {28'd0, mem_wstrb}, 32'd0);
    rst = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i]);

    // start pulses in REQ, WAIT and DONE must be ignored; only one done for the load
    dones = 0; got = 32'd0; got_mis = 1'b1;
    @(negedge clk);
    start = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h2004;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      start = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
      if (done) begin
        dones++;
        got = rdata;
        got_mis = misaligned;
      end
      if (c == 1 || c == 3 || c == 4) begin
        start = 1'b1; is_store = 1'b1; funct3 = 3'b011; addr = 32'h1001;
      end
      if (c == 2) mem_gnt = 1'b1;
      if (c == 3) begin
        mem_rvalid = 1'b1;
        mem_rdata = 32'h5A5A_0001;
      end
    end
    check_i("busy-start done count", dones, 1);
    check("busy-start rdata", got, 32'h5A5A_0001);
    check_b("busy-start misaligned", got_mis, 1'b0);

    // rst during WAIT, then a late rvalid
    @(negedge clk);
    start = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h2000;
    @(negedge clk);
    start = 1'b0;
    check_b("rstwait mem_req", mem_req, 1'b1);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    check_b("rstwait in WAIT", busy & ~mem_req, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_b("rstwait busy", busy, 1'b0);
    check_b("rstwait mem_req", mem_req, 1'b0);
    check("rstwait mem_addr", mem_addr, 32'd0);
    mem_rvalid = 1'b1;
    mem_rdata = 32'h1111_1111;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      mem_rvalid = 1'b0;
      check_b("rstwait done", done, 1'b0);
      check_b("rstwait idle", busy, 1'b0);
      check("rstwait rdata", rdata, 32'd0);
    end

    // rst wins over start in the same cycle
    @(negedge clk);
    rst = 1'b1; start = 1'b1; is_store = 1'b1; funct3 = 3'b010; addr = 32'h1000;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    check_b("rst+start busy", busy, 1'b0);
    check_b("rst+start mem_req", mem_req, 1'b0);
    @(negedge clk);
    check_b("rst+start still idle", busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
